// File: rtl/generic_trig_counter.sv
// -----------------------------------------------------------------------------
// generic_trig_counter
//
// Modulo-(COUNTER_MAX+1) up-counter with a one-cycle terminal-count strobe.
// This is the timebase/prescaler primitive. Instances cascade by feeding one
// TRIG_OUT into the next ENABLE_IN (or CLK).
//
// Parameters
//   COUNTER_WIDTH  bit width of COUNT (>= 1)
//   COUNTER_MAX    terminal value, 0 <= COUNTER_MAX <= 2^COUNTER_WIDTH-1
//
// Ports
//   CLK        in   1              rising-edge clock
//   RESET      in   1              asynchronous reset, active low
//   ENABLE_IN  in   1              count enable, sampled on rising CLK
//   LOAD_IN    in   1              synchronous load (optional, see below)
//   LOAD_VAL   in   COUNTER_WIDTH  load value, clamped to COUNTER_MAX (optional)
//   TRIG_OUT   out  1              registered strobe, high in the cycle COUNT
//                                  reads 0 after a wrap
//   COUNT      out  COUNTER_WIDTH  registered current count
//
// Optional feature
//   Define GENERIC_TRIG_COUNTER_LOAD_EN to add LOAD_IN/LOAD_VAL. A load wins
//   over ENABLE_IN and clears the strobe; RESET still wins over a load.
//
// This block has no FSM and no valid/ready handshake: COUNT and TRIG_OUT are
// presented every cycle.
// -----------------------------------------------------------------------------
module generic_trig_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE_IN,
`ifdef GENERIC_TRIG_COUNTER_LOAD_EN
  input  logic                     LOAD_IN,
  input  logic [COUNTER_WIDTH-1:0] LOAD_VAL,
`endif
  output logic                     TRIG_OUT,
  output logic [COUNTER_WIDTH-1:0] COUNT
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (COUNTER_WIDTH < 1) begin : g_bad_width
    $error("generic_trig_counter: COUNTER_WIDTH must be >= 1");
  end

  if ((COUNTER_MAX < 0) ||
      ((COUNTER_WIDTH < 62) &&
       (longint'(COUNTER_MAX) > ((longint'(1) << COUNTER_WIDTH) - 1)))) begin : g_bad_max
    $error("generic_trig_counter: COUNTER_MAX out of range for COUNTER_WIDTH");
  end

  localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = COUNTER_WIDTH'(COUNTER_MAX);
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Load path (compiled out when the feature is disabled)
  // ---------------------------------------------------------------------------
  logic                     load_req;
  logic [COUNTER_WIDTH-1:0] load_clamped;

`ifdef GENERIC_TRIG_COUNTER_LOAD_EN
  // When COUNTER_MAX fills the whole width every LOAD_VAL is already legal,
  // so the clamp comparator is left out (it would be constant anyway).
  localparam bit FULL_RANGE =
    (COUNTER_WIDTH < 62) &&
    (longint'(COUNTER_MAX) == ((longint'(1) << COUNTER_WIDTH) - 1));

  if (FULL_RANGE) begin : g_load_noclamp
    assign load_clamped = LOAD_VAL;
  end else begin : g_load_clamp
    assign load_clamped = (LOAD_VAL > MAX_VAL) ? MAX_VAL : LOAD_VAL;
  end

  assign load_req = LOAD_IN;
`else
  assign load_req     = 1'b0;
  assign load_clamped = '0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic                     at_max;
  logic [COUNTER_WIDTH-1:0] count_inc;
  logic [COUNTER_WIDTH-1:0] count_next;
  logic                     trig_next;

  assign at_max    = (COUNT == MAX_VAL);
  assign count_inc = COUNT + ONE;

  // The wrap is an explicit clear on the terminal value rather than relying on
  // overflow, so MAX = 2^W-1 and MAX = 0 both fall out of the same compare.
  // The strobe defaults low every cycle, so it can never stretch over a stall.
  always_comb begin
    count_next = COUNT;
    trig_next  = 1'b0;
    if (load_req) begin
      count_next = load_clamped;
    end else if (ENABLE_IN) begin
      if (at_max) begin
        count_next = '0;
        trig_next  = 1'b1;
      end else begin
        count_next = count_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers: both outputs come straight from these flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      COUNT    <= '0;
      TRIG_OUT <= 1'b0;
    end else begin
      COUNT    <= count_next;
      TRIG_OUT <= trig_next;
    end
  end

endmodule

// File: tb/tb_generic_trig_counter.sv
// -----------------------------------------------------------------------------
// tb_generic_trig_counter
//
// Four counter instances share clock, reset and enable:
//   a: W=4, MAX=9   (carries the load ports when the load feature is built)
//   b: W=3, MAX=7   (full-range wrap)
//   c: W=2, MAX=0   (divide-by-1)
//   d: W=1, MAX=1   (full-range, single bit)
// The reference model tracks each counter as a position modulo (MAX+1);
// expected {trig, count} words are queued per instance when stimulus is
// issued and popped by an independent monitor after every rising edge.
// -----------------------------------------------------------------------------
module tb_generic_trig_counter;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [3:0] load_val = '0;

  always #5 clk = ~clk;

`ifdef GENERIC_TRIG_COUNTER_LOAD_EN
  localparam bit LOAD_BUILT = 1'b1;
`else
  localparam bit LOAD_BUILT = 1'b0;
`endif

  logic       trig_a, trig_b, trig_c, trig_d;
  logic [3:0] count_a;
  logic [2:0] count_b;
  logic [1:0] count_c;
  logic [0:0] count_d;

  generic_trig_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(9)) dut_a (
    .CLK(clk), .RESET(rst_n), .ENABLE_IN(enable),
`ifdef GENERIC_TRIG_COUNTER_LOAD_EN
    .LOAD_IN(load), .LOAD_VAL(load_val),
`endif
    .TRIG_OUT(trig_a), .COUNT(count_a));

  generic_trig_counter #(.COUNTER_WIDTH(3), .COUNTER_MAX(7)) dut_b (
    .CLK(clk), .RESET(rst_n), .ENABLE_IN(enable),
`ifdef GENERIC_TRIG_COUNTER_LOAD_EN
    .LOAD_IN(1'b0), .LOAD_VAL(3'd0),
`endif
    .TRIG_OUT(trig_b), .COUNT(count_b));

  generic_trig_counter #(.COUNTER_WIDTH(2), .COUNTER_MAX(0)) dut_c (
    .CLK(clk), .RESET(rst_n), .ENABLE_IN(enable),
`ifdef GENERIC_TRIG_COUNTER_LOAD_EN
    .LOAD_IN(1'b0), .LOAD_VAL(2'd0),
`endif
    .TRIG_OUT(trig_c), .COUNT(count_c));

  generic_trig_counter #(.COUNTER_WIDTH(1), .COUNTER_MAX(1)) dut_d (
    .CLK(clk), .RESET(rst_n), .ENABLE_IN(enable),
`ifdef GENERIC_TRIG_COUNTER_LOAD_EN
    .LOAD_IN(1'b0), .LOAD_VAL(1'b0),
`endif
    .TRIG_OUT(trig_d), .COUNT(count_d));

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [4:0] exp_q[4][$];
  int         pos[4];
  int         mx[4] = '{9, 7, 0, 1};
  int         errors = 0;
  int         checks = 0;
  int         pulses_a = 0;

  function automatic logic [4:0] actual(input int i);
    case (i)
      0:       return {trig_a, count_a};
      1:       return {trig_b, 1'b0, count_b};
      2:       return {trig_c, 2'b00, count_c};
      default: return {trig_d, 3'b000, count_d};
    endcase
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got trig=%0b count=%0d, expected trig=%0b count=%0d at %0t",
               name, act[4], act[3:0], expv[4], expv[3:0], $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of stimulus and queue the model's prediction
  // ---------------------------------------------------------------------------
  task automatic step(input logic en, input logic rst, input logic ld, input logic [3:0] lv);
    @(negedge clk);
    enable   = en;
    rst_n    = rst;
    load     = ld & LOAD_BUILT;
    load_val = lv;
    for (int i = 0; i < 4; i++) begin
      logic t;
      t = 1'b0;
      if (!rst) begin
        pos[i] = 0;
      end else if (ld && LOAD_BUILT && i == 0) begin
        pos[i] = (int'(lv) > mx[0]) ? mx[0] : int'(lv);
      end else if (en) begin
        pos[i] = (pos[i] + 1) % (mx[i] + 1);
        t = (pos[i] == 0);
      end
      exp_q[i].push_back({t, 4'(pos[i])});
    end
  endtask

  task automatic run(input int n, input logic en);
    for (int k = 0; k < n; k++) step(en, 1'b1, 1'b0, 4'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare every instance after each rising edge
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (exp_q[i].size() > 0) begin
          logic [4:0] e;
          logic [4:0] a;
          e = exp_q[i].pop_front();
          a = actual(i);
          check($sformatf("edge_dut%0d", i), a, e);
          if (i == 0 && a[4]) pulses_a++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus sequence
  // ---------------------------------------------------------------------------
  initial begin
    int p0;
    int budget;
    for (int i = 0; i < 4; i++) pos[i] = 0;

    // Test 1: reset holds outputs at 0 without any clock edge, then count.
    #1;
    check("reset_no_edge", actual(0), 5'b0_0000);
    repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0);
    run(10, 1'b1);

    // Test 2: free run, 5 pulses in 50 cycles on the MAX=9 instance.
    @(posedge clk);
    #2;
    p0 = pulses_a;
    run(50, 1'b1);
    @(posedge clk);
    #2;
    check("free_run_pulses", 5'(pulses_a - p0), 5'd5);

    // Test 3: stall at COUNT=9, then wrap on the next enabled edge.
    run(9, 1'b1);
    run(4, 1'b0);
    run(1, 1'b1);

    // Test 4: asynchronous reset between edges while COUNT=6.
    run(6, 1'b1);
    @(posedge clk);
    #2;
    check("pre_async_count6", actual(0), 5'b0_0110);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_a", actual(0), 5'b0_0000);
    check("async_reset_b", actual(1), 5'b0_0000);
    for (int i = 0; i < 4; i++) pos[i] = 0;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    run(12, 1'b1);

    // Test 5: full-range and divide-by-1 instances under long runs.
    run(20, 1'b1);

    // Test 6: load with clamp, then wrap on the next enabled edge.
    if (LOAD_BUILT) begin
      run(3, 1'b1);
      step(1'b1, 1'b1, 1'b1, 4'd12);
      step(1'b1, 1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b1, 4'd4);
      step(1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b1, 4'd7);
    end

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 31) != 0,
           $urandom_range(0, 7) == 0,
           4'($urandom_range(0, 15)));
    end
    run(12, 1'b1);

    // Drain with a bounded wait.
    budget = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expected entries left, required 0",
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
